// File: rtl/bus_seq_pkg.sv
// Shared types and code constants for the bus sequencer.
package bus_seq_pkg;

    localparam int FIFO_DEPTH = 4;
    localparam int REQ_W      = 7;

    localparam logic [3:0] SRC_NONE = 4'b0000;
    localparam logic [3:0] SRC_LO_A = 4'b0001;
    localparam logic [3:0] SRC_HI_A = 4'b0011;
    localparam logic [3:0] SRC_LO_B = 4'b0101;
    localparam logic [3:0] SRC_HI_B = 4'b1011;

    localparam logic [2:0] DST_NONE = 3'b000;
    localparam logic [2:0] DST_R2   = 3'b010;
    localparam logic [2:0] DST_R3   = 3'b011;
    localparam logic [2:0] DST_SR   = 3'b110;

    typedef enum logic [2:0] {IDLE, SRC, DST, ACK, FIN} state_t;

    typedef struct packed {
        logic [3:0] src;
        logic [2:0] dst;
    } req_t;

    function automatic logic src_legal(input logic [3:0] s);
        return (s >= SRC_LO_A && s <= SRC_HI_A) || (s >= SRC_LO_B && s <= SRC_HI_B);
    endfunction

    function automatic logic dst_legal(input logic [2:0] d);
        return d inside {DST_NONE, DST_R2, DST_R3, DST_SR};
    endfunction

endpackage

// File: rtl/bus_seq_fifo.sv
// Small request FIFO with occupancy count and full/empty flags.
module bus_seq_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/bus_sequencer.sv
// Bus transfer sequencer: SRC/DST phases, optional SR acknowledge.
// Define BUS_SEQ_FIFO_EN to queue requests in a FIFO instead of one holding register.
module bus_sequencer
    import bus_seq_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       req_valid,
    input  logic [3:0] req_src,
    input  logic [2:0] req_dst,
    output logic       req_ready,
    output logic [3:0] select_source,
    output logic [2:0] select_destination,
    input  logic       sr_en,
    output logic       busy,
    output logic       done,
    output logic       err
);
    state_t     state;
    req_t       req_in, head;
    logic [2:0] cur_dst;
    logic       push, pop, q_empty, q_nonempty;

    assign req_in = '{src: req_src, dst: req_dst};
    assign push   = req_valid && req_ready;
    assign pop    = (state == IDLE) && !q_empty;
    assign busy   = (state != IDLE) || q_nonempty;

`ifdef BUS_SEQ_FIFO_EN
    logic                            q_full;
    logic [$clog2(FIFO_DEPTH+1)-1:0] q_count;

    bus_seq_fifo #(.WIDTH(REQ_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .din     (req_in),
        .pop     (pop),
        .dout    (head),
        .count   (q_count),
        .full    (q_full),
        .empty   (q_empty)
    );

    assign req_ready  = reset_n && !q_full;
    assign q_nonempty = (q_count != '0);
`else
    req_t hold_q;
    logic hold_vld;

    // Only one request in flight: accept strictly while idle and empty.
    assign req_ready  = reset_n && (state == IDLE) && !hold_vld;
    assign head       = hold_q;
    assign q_empty    = !hold_vld;
    assign q_nonempty = hold_vld;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_vld <= 1'b0;
            hold_q   <= '0;
        end else if (push) begin
            hold_vld <= 1'b1;
            hold_q   <= req_in;
        end else if (pop) begin
            hold_vld <= 1'b0;
        end
    end
`endif

    // Outputs are registered for the state being entered.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            cur_dst            <= DST_NONE;
            select_source      <= SRC_NONE;
            select_destination <= DST_NONE;
            done               <= 1'b0;
            err                <= 1'b0;
        end else begin
            done               <= 1'b0;
            err                <= 1'b0;
            select_source      <= SRC_NONE;
            select_destination <= DST_NONE;
            case (state)
                IDLE: if (pop) begin
                    if (src_legal(head.src) && dst_legal(head.dst)) begin
                        state         <= SRC;
                        cur_dst       <= head.dst;
                        select_source <= head.src;
                    end else begin
                        err <= 1'b1;
                    end
                end
                SRC: begin
                    state              <= DST;
                    select_destination <= cur_dst;
                end
                DST: begin
                    if (cur_dst == DST_SR) begin
                        state <= ACK;
                    end else begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end
                ACK: begin
                    if (sr_en) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        err   <= 1'b1;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_sequencer.sv
// Scoreboard bench for bus_sequencer; FIFO scenarios run when BUS_SEQ_FIFO_EN is defined.
module tb_bus_sequencer;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       req_valid = 1'b0;
    logic [3:0] req_src = '0;
    logic [2:0] req_dst = '0;
    logic       sr_en = 1'b0;
    logic       req_ready, busy, done, err;
    logic [3:0] select_source;
    logic [2:0] select_destination;

    bus_sequencer dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .req_valid          (req_valid),
        .req_src            (req_src),
        .req_dst            (req_dst),
        .req_ready          (req_ready),
        .select_source      (select_source),
        .select_destination (select_destination),
        .sr_en              (sr_en),
        .busy               (busy),
        .done               (done),
        .err                (err)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       done;
        logic [3:0] src;
        logic [2:0] dst;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_done = 0;
    logic [3:0] seen_src = '0;
    logic [2:0] seen_dst = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic m_legal(input logic [3:0] s, input logic [2:0] d);
        return (s inside {[4'd1:4'd3], [4'd5:4'd11]}) && (d inside {3'd0, 3'd2, 3'd3, 3'd6});
    endfunction

    function automatic exp_t m_result(input logic [3:0] s, input logic [2:0] d, input logic sr);
        exp_t e;
        if (m_legal(s, d)) e = '{done: (d != 3'd6) || sr, src: s, dst: d};
        else               e = '{done: 1'b0, src: 4'd0, dst: 3'd0};
        return e;
    endfunction

    // Scoreboard: every done/err pulse retires the oldest expected transfer.
    always @(negedge clock) begin : mon
        exp_t e;
        if (!reset_n) begin
            seen_src = '0;
            seen_dst = '0;
        end else begin
            if (select_source != 4'd0)      seen_src = select_source;
            if (select_destination != 3'd0) seen_dst = select_destination;
            if (done || err) begin
                chk("sb_pending", exp_q.size() > 0, 1);
                chk("done_err_excl", done & err, 0);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("sb_kind", done, e.done);
                    chk("sb_src", seen_src, e.src);
                    chk("sb_dst", seen_dst, e.dst);
                end
                if (done) n_done++;
                seen_src = '0;
                seen_dst = '0;
            end
        end
    end

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic push_req(input logic [3:0] s, input logic [2:0] d);
        int k;
        req_valid = 1'b1;
        req_src   = s;
        req_dst   = d;
        for (k = 0; k < 50; k++) begin
            if (req_ready) break;
            @(negedge clock);
        end
        chk("ready_timeout", req_ready, 1);
        @(posedge clock);
        exp_q.push_back(m_result(s, d, sr_en));
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic xfer(input logic [3:0] s, input logic [2:0] d, input logic sr);
        int   lat;
        logic legal;
        legal = m_legal(s, d);
        lat   = 0;
        sr_en = sr;
        push_req(s, d);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (k == 1) begin
                chk("src_cyc_src", select_source, legal ? s : 4'd0);
                chk("src_cyc_dst", select_destination, 0);
            end
            if (k == 2) begin
                chk("dst_cyc_src", select_source, 0);
                chk("dst_cyc_dst", select_destination, legal ? d : 3'd0);
            end
            if (done || err) begin
                lat = k;
                break;
            end
        end
        chk("latency", lat, !legal ? 1 : (d == 3'd6 ? 4 : 3));
        chk("pulse_kind", done, legal && (d != 3'd6 || sr));
        @(negedge clock);
        chk("pulse_single", done | err, 0);
        chk("idle_sel", {select_source, select_destination}, 0);
        sr_en = 1'b0;
    endtask

    task automatic wait_idle(output logic last_done);
        int   k;
        logic pd;
        pd = 1'b0;
        for (k = 0; k < 200; k++) begin
            @(negedge clock);
            if (!busy) break;
            pd = done;
        end
        chk("idle_timeout", k < 200, 1);
        last_done = pd;
    endtask

    initial begin
        logic ld;
        #1 reset_n = 1'b0;
        #2;
        chk("rst_src", select_source, 0);
        chk("rst_dst", select_destination, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("idle_ready", req_ready, 1);

        xfer(4'd1, 3'd2, 1'b0);   // basic non-SR
        xfer(4'd6, 3'd6, 1'b1);   // SR acknowledged
        xfer(4'd6, 3'd6, 1'b0);   // SR refused
        xfer(4'd4, 3'd2, 1'b0);   // illegal source
        xfer(4'd3, 3'd0, 1'b0);   // load-bus-only destination
        xfer(4'd11, 3'd3, 1'b0);  // top legal source
        xfer(4'd12, 3'd2, 1'b0);
        xfer(4'd0, 3'd2, 1'b0);
        xfer(4'd5, 3'd7, 1'b0);   // illegal destination

        // Reset while the DST phase is on the bus.
        push_req(4'd2, 3'd3);
        @(negedge clock);
        @(negedge clock);
        chk("pre_rst_dst", select_destination, 3);
        exp_q.delete();
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_src", select_source, 0);
        chk("mid_rst_dst", select_destination, 0);
        chk("mid_rst_pulse", done | err, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", req_ready, 0);
        @(negedge clock);
        #2 reset_n = 1'b1;
        @(negedge clock);
        chk("post_rst_busy", busy, 0);
        xfer(4'd9, 3'd2, 1'b0);

`ifdef BUS_SEQ_FIFO_EN
        begin
            int base;
            logic [3:0] ss [5] = '{4'd1, 4'd3, 4'd5, 4'd9, 4'd11};
            logic [2:0] dd [5] = '{3'd2, 3'd3, 3'd0, 3'd6, 3'd2};
            base  = n_done;
            sr_en = 1'b1;
            push_req(4'd7, 3'd6);   // keeps the FSM busy while the FIFO fills
            for (int i = 0; i < 5; i++) begin
                push_req(ss[i], dd[i]);
                if (i == 3) chk("full_ready", req_ready, 0);
            end
            wait_idle(ld);
            chk("busy_after_fin", ld, 1);
            chk("stream_done_cnt", n_done - base, 6);
            sr_en = 1'b0;
        end

        // A request accepted during FIN is popped in the next IDLE cycle.
        begin
            int k;
            push_req(4'd1, 3'd2);
            for (k = 0; k < 10; k++) begin
                @(negedge clock);
                if (done) break;
            end
            chk("fin_seen", done, 1);
            push_req(4'd7, 3'd3);
            chk("gap_src", select_source, 0);
            chk("gap_dst", select_destination, 0);
            chk("gap_busy", busy, 1);
            @(negedge clock);
            chk("fin_next_src", select_source, 7);
            chk("fin_next_dst", select_destination, 0);
            wait_idle(ld);
            chk("fin_next_done", ld, 1);
        end
`endif

        wait_idle(ld);
        @(negedge clock);
        chk("sb_drained", exp_q.size(), 0);
        chk("end_busy", busy, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
